// File: rtl/verificador_nonce.sv
// verificador_nonce
// Receiving end of the nonce stream from generador_nonce. It throttles the
// generator, queues nonces that are in flight through the hash core, lines
// each hash result up with the nonce that produced it, and stops the search
// on the first winning nonce or when the all-ones nonce has been checked.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, dominant
//   start        one-cycle pulse, begins a new search (IDLE/FOUND/EXHAUSTED)
//   target       threshold, captured on the accepted start pulse
//   nonce_valid  generator produced a nonce this cycle
//   nonce        nonce from the generator
//   hash_valid   hash core result valid (results arrive in nonce order)
//   hash         hash result
//   gen_enable   drives the generator's valid input
//   found        a winning nonce is latched in golden_nonce
//   golden_nonce the winning nonce
//   exhausted    the all-ones nonce was checked without a win
//   error        sticky protocol error (push while full / pop while empty)
//   inflight     current FIFO occupancy
module verificador_nonce #(
    parameter int NONCE_W = 24,
    parameter int HASH_W  = 24,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [HASH_W-1:0]  target,
    input  logic               nonce_valid,
    input  logic [NONCE_W-1:0] nonce,
    input  logic               hash_valid,
    input  logic [HASH_W-1:0]  hash,
    output logic               gen_enable,
    output logic               found,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic               exhausted,
    output logic               error,
    output logic [CNT_W-1:0]   inflight
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEARCH, FOUND, EXHAUSTED} state_t;

    state_t               state_reg, state_next;
    logic [NONCE_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [HASH_W-1:0]    target_reg, target_next;
    logic [NONCE_W-1:0]   golden_reg, golden_next;
    logic                 found_reg, found_next;
    logic                 exhausted_reg, exhausted_next;
    logic                 error_reg, error_next;
    logic                 gen_enable_reg, gen_enable_next;
    logic                 do_write;

    logic [NONCE_W-1:0]   head;
    logic                 fifo_empty, fifo_full;
    logic                 can_pop, can_push, pop_empty, push_full;
    logic                 win;

    // The head must be compared in the same cycle hash_valid arrives, so the
    // queue is read asynchronously (small distributed RAM, not block RAM).
    assign head       = fifo_mem[rd_ptr_reg];
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(DEPTH));

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_pop    = hash_valid && !fifo_empty;
    assign pop_empty  = hash_valid && fifo_empty;
    assign can_push   = nonce_valid && (!fifo_full || can_pop);
    assign push_full  = nonce_valid && !can_push;
    assign win        = can_pop && (hash < target_reg);

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        target_next    = target_reg;
        golden_next    = golden_reg;
        found_next     = found_reg;
        exhausted_next = exhausted_reg;
        error_next     = error_reg;
        do_write       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SEARCH;
                    target_next = target;
                    wr_ptr_next = '0;
                    rd_ptr_next = '0;
                    count_next  = '0;
                end
            end
            SEARCH: begin
                if (can_push) begin
                    do_write    = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                end
                if (can_pop) begin
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                end
                count_next = count_reg + CNT_W'(can_push) - CNT_W'(can_pop);
                if (push_full || pop_empty) begin
                    error_next = 1'b1;
                end
                // Win is checked first so it beats exhaustion on the same pop.
                if (win) begin
                    found_next  = 1'b1;
                    golden_next = head;
                    state_next  = FOUND;
                end else if (can_pop && (&head)) begin
                    exhausted_next = 1'b1;
                    state_next     = EXHAUSTED;
                end
                // Leaving the search flushes whatever is still in flight.
                if (state_next != SEARCH) begin
                    wr_ptr_next = '0;
                    rd_ptr_next = '0;
                    count_next  = '0;
                end
            end
            default: begin  // FOUND, EXHAUSTED: late traffic is discarded
                wr_ptr_next = '0;
                rd_ptr_next = '0;
                count_next  = '0;
                if (start) begin
                    state_next     = SEARCH;
                    target_next    = target;
                    found_next     = 1'b0;
                    exhausted_next = 1'b0;
                    error_next     = 1'b0;
                end
            end
        endcase

        // Throttle with a two-entry margin to absorb generator latency.
        gen_enable_next = (state_next == SEARCH) && (count_next <= CNT_W'(DEPTH - 3));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            target_reg     <= '0;
            golden_reg     <= '0;
            found_reg      <= 1'b0;
            exhausted_reg  <= 1'b0;
            error_reg      <= 1'b0;
            gen_enable_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            target_reg     <= target_next;
            golden_reg     <= golden_next;
            found_reg      <= found_next;
            exhausted_reg  <= exhausted_next;
            error_reg      <= error_next;
            gen_enable_reg <= gen_enable_next;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            fifo_mem[wr_ptr_reg] <= nonce;
        end
    end

    assign gen_enable   = gen_enable_reg;
    assign found        = found_reg;
    assign golden_nonce = golden_reg;
    assign exhausted    = exhausted_reg;
    assign error        = error_reg;
    assign inflight     = count_reg;

endmodule

// File: tb/tb_verificador_nonce.sv
// Testbench for verificador_nonce: directed scenarios plus randomized
// traffic, each cycle's expected outputs produced by a queue-based model
// and checked by an independent monitor process.
module tb_verificador_nonce;

    localparam int NW    = 24;
    localparam int HW    = 24;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [HW-1:0] target = '0;
    logic          nonce_valid = 1'b0;
    logic [NW-1:0] nonce = '0;
    logic          hash_valid = 1'b0;
    logic [HW-1:0] hash = '0;
    logic          gen_enable;
    logic          found;
    logic [NW-1:0] golden_nonce;
    logic          exhausted;
    logic          error;
    logic [CW-1:0] inflight;

    verificador_nonce #(
        .NONCE_W(NW), .HASH_W(HW), .DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .nonce_valid(nonce_valid), .nonce(nonce),
        .hash_valid(hash_valid), .hash(hash),
        .gen_enable(gen_enable), .found(found), .golden_nonce(golden_nonce),
        .exhausted(exhausted), .error(error), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_SEARCH = 1, M_FOUND = 2, M_EXH = 3;
    int            m_mode = M_IDLE;
    logic [NW-1:0] m_q[$];
    logic [HW-1:0] m_tgt = '0;
    logic          m_found = 0, m_exh = 0, m_err = 0;
    logic [NW-1:0] m_golden = '0;

    typedef struct {
        logic          gen;
        logic          fnd;
        logic          exh;
        logic          err;
        logic [NW-1:0] gold;
        int            infl;
    } exp_t;
    exp_t sb_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic model_update(input logic rst, input logic st, input logic [HW-1:0] tg,
                                input logic nv, input logic [NW-1:0] n,
                                input logic hv, input logic [HW-1:0] h);
        logic [NW-1:0] hd;
        logic popped;
        hd = '0;
        popped = 0;
        if (rst) begin
            m_mode = M_IDLE; m_q.delete();
            m_found = 0; m_exh = 0; m_err = 0; m_golden = '0;
        end else if (m_mode == M_IDLE) begin
            if (st) begin m_mode = M_SEARCH; m_tgt = tg; m_q.delete(); end
        end else if (m_mode == M_SEARCH) begin
            if (hv) begin
                if (m_q.size() == 0) m_err = 1;
                else begin hd = m_q.pop_front(); popped = 1; end
            end
            if (nv) begin
                if (m_q.size() < DEPTH) m_q.push_back(n);
                else m_err = 1;
            end
            if (popped && (h < m_tgt)) begin
                m_found = 1; m_golden = hd; m_mode = M_FOUND; m_q.delete();
            end else if (popped && (hd == 24'hFFFFFF)) begin
                m_exh = 1; m_mode = M_EXH; m_q.delete();
            end
        end else begin
            m_q.delete();
            if (st) begin
                m_mode = M_SEARCH; m_tgt = tg;
                m_found = 0; m_exh = 0; m_err = 0;
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, queue the expectation.
    task automatic step(input logic rst, input logic st, input logic [HW-1:0] tg,
                        input logic nv, input logic [NW-1:0] n,
                        input logic hv, input logic [HW-1:0] h);
        exp_t e;
        reset = rst; start = st; target = tg;
        nonce_valid = nv; nonce = n; hash_valid = hv; hash = h;
        model_update(rst, st, tg, nv, n, hv, h);
        e.gen  = (m_mode == M_SEARCH) && (m_q.size() <= DEPTH - 3);
        e.fnd  = m_found;
        e.exh  = m_exh;
        e.err  = m_err;
        e.gold = m_golden;
        e.infl = m_q.size();
        @(posedge clk);
        #1;
        sb_q.push_back(e);
        reset = 0; start = 0; nonce_valid = 0; hash_valid = 0;
    endtask

    task automatic idle_step();
        step(0, 0, '0, 0, '0, 0, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (gen_enable !== e.gen || found !== e.fnd || exhausted !== e.exh ||
                error !== e.err || golden_nonce !== e.gold || int'(inflight) != e.infl) begin
                miscompares++;
                $display("FAIL vec %0d outputs: got gen=%0b found=%0b exh=%0b err=%0b golden=%06h inflight=%0d, want gen=%0b found=%0b exh=%0b err=%0b golden=%06h inflight=%0d",
                         vectors, gen_enable, found, exhausted, error, golden_nonce, inflight,
                         e.gen, e.fnd, e.exh, e.err, e.gold, e.infl);
            end else begin
                $display("vec %0d ok: gen=%0b found=%0b exh=%0b err=%0b golden=%06h inflight=%0d",
                         vectors, gen_enable, found, exhausted, error, golden_nonce, inflight);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [NW-1:0] gen_nonce;
    logic          nv_d;

    initial begin
        logic [HW-1:0] hashes [3];
        logic          r_rst, r_st, r_nv, r_hv;
        logic [HW-1:0] r_tg, r_h;
        int            r;

        // Reset held two cycles, then idle.
        step(1, 0, '0, 0, '0, 0, '0);
        step(1, 0, '0, 0, '0, 0, '0);
        idle_step();
        // Hash in IDLE is ignored.
        step(0, 0, '0, 0, '0, 1, 24'h000000);

        // Basic win.
        hashes[0] = 24'hFFFFFF; hashes[1] = 24'h800000; hashes[2] = 24'h000FFF;
        step(0, 1, 24'h001000, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, NW'(i), 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, 1, hashes[i]);
        step(0, 0, '0, 1, 24'h000005, 1, 24'h000000);   // late traffic in FOUND
        idle_step();

        // Protocol errors, then start from FOUND clears error.
        step(0, 1, 24'h000010, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0, 1, 24'hFFFFFF);            // pop while empty
        for (int i = 0; i < 9; i++) step(0, 0, '0, 1, NW'(24'h000100 + i), 0, '0);
        step(0, 0, '0, 0, '0, 1, 24'h000010);            // hash == target: no win
        step(0, 0, '0, 0, '0, 1, 24'h00000F);            // target-1: win
        step(0, 1, 24'h000010, 0, '0, 0, '0);

        // Exhaustion (win impossible with target 0).
        step(0, 1, 24'h000000, 0, '0, 0, '0);            // ignored in SEARCH
        step(1, 0, '0, 0, '0, 0, '0);
        step(0, 1, 24'h000000, 0, '0, 0, '0);
        step(0, 0, '0, 1, 24'hFFFFFE, 0, '0);
        step(0, 0, '0, 1, 24'hFFFFFF, 0, '0);
        step(0, 0, '0, 0, '0, 1, 24'h000000);
        step(0, 0, '0, 0, '0, 1, 24'h000000);
        step(0, 0, '0, 1, 24'h000000, 1, 24'h000000);    // late traffic in EXHAUSTED
        idle_step();

        // Backpressure: generator follows gen_enable one cycle late.
        step(0, 1, 24'h000000, 0, '0, 0, '0);
        nv_d = 0;
        gen_nonce = 24'h000040;
        for (int i = 0; i < 20; i++) begin
            r_nv = nv_d;
            nv_d = gen_enable;
            step(0, 0, '0, r_nv, gen_nonce, 0, '0);
            if (r_nv) gen_nonce = gen_nonce + 1'b1;
        end

        // Reset mid-search coinciding with a winning hash.
        step(1, 0, '0, 0, '0, 0, '0);
        step(0, 1, 24'h800000, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, NW'(24'h000200 + i), 0, '0);
        step(1, 0, '0, 0, '0, 1, 24'h000000);
        step(0, 0, '0, 1, 24'h000300, 1, 24'h000000);    // IDLE ignores traffic
        idle_step();

        // Randomized traffic.
        nv_d = 0;
        gen_nonce = 24'h000000;
        for (int i = 0; i < 400; i++) begin
            r_rst = 0; r_st = 0; r_tg = '0;
            r = int'($urandom % 100);
            if (r == 0) begin
                r_rst = 1;
            end else if (m_mode != M_SEARCH && r < 30) begin
                r_st = 1;
                case ($urandom % 4)
                    0: r_tg = 24'h000000;
                    1: r_tg = 24'h001000;
                    2: r_tg = 24'h400000;
                    default: r_tg = HW'($urandom);
                endcase
                gen_nonce = ($urandom % 3 == 0) ? NW'(24'hFFFFF0 + ($urandom % 16))
                                                 : NW'($urandom);
            end else if (m_mode == M_SEARCH && r < 3) begin
                r_st = 1;
                r_tg = HW'($urandom);
            end
            r_nv = ($urandom % 10 < 8) ? nv_d : logic'($urandom % 2);
            nv_d = gen_enable;
            r_hv = ($urandom % 100) < 35;
            r = int'($urandom % 20);
            if (r == 0 && m_tgt != 0) r_h = HW'($urandom_range(0, int'(m_tgt) - 1));
            else if (r == 1) r_h = m_tgt;
            else r_h = HW'($urandom) | 24'h800000;
            step(r_rst, r_st, r_tg, r_nv, gen_nonce, r_hv, r_h);
            if (r_nv) gen_nonce = gen_nonce + 1'b1;
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
